// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with glitch-free start/stop
// and a valid/ready divisor update applied at period boundaries.
module clk_div_ctrl #(
  parameter int W       = 8,
  parameter int DEF_DIV = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         div_valid,
  output logic         div_ready,
  output logic         clk_out,
  output logic         tick,
  output logic         busy,
  output logic [W-1:0] cur_div,
  output logic         err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [W-1:0] DEF = W'(DEF_DIV);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cur_q, cur_d;
  logic [W-1:0] nxt_q, nxt_d;
  logic         pend_q, pend_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic         err_q, err_d;

  logic         accept;
  logic         bad;
  logic         last;
  logic [W-1:0] cnt_inc;
  logic [W-1:0] half;

  assign accept  = div_valid && !pend_q;
  assign bad     = div_in < TWO;
  assign last    = cnt_q == (cur_q - ONE);
  assign cnt_inc = cnt_q + ONE;
  assign half    = cur_q >> 1;

  // State register; reset aborts any period and drops a pending update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= DEF;
      nxt_q   <= DEF;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  // Next-state: counting, boundary handling and divisor handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    err_d   = accept && bad;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        // An update caught on the stopping boundary lands here
        if (pend_q) begin
          cur_d  = nxt_q;
          pend_d = 1'b0;
        end
        if (accept && !bad) cur_d = div_in;
        if (en) begin
          state_d = RUN;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end
      RUN: begin
        if (!last) begin
          cnt_d = cnt_inc;
          clk_d = cnt_inc < half;
        end else begin
          cnt_d = '0;
          if (pend_q) begin
            cur_d  = nxt_q;
            pend_d = 1'b0;
          end
          if (en) begin
            clk_d  = 1'b1;
            tick_d = 1'b1;
          end else begin
            state_d = IDLE;
            clk_d   = 1'b0;
          end
        end
        // Acceptance only when nothing pends, so no clash with apply
        if (accept && !bad) begin
          nxt_d  = div_in;
          pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign div_ready = !pend_q;
  assign clk_out   = clk_q;
  assign tick      = tick_q;
  assign busy      = state_q == RUN;
  assign cur_div   = cur_q;
  assign err       = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl
// with hand-computed expectations.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] div_in;
  logic       div_valid;
  logic       div_ready;
  logic       clk_out;
  logic       tick;
  logic       busy;
  logic [7:0] cur_div;
  logic       err;

  int passed = 0;
  int total  = 0;

  clk_div_ctrl #(.W(8), .DEF_DIV(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .cur_div   (cur_div),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    div_in    = 8'd0;
    div_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cur", int'(cur_div), 5);
    chk("rst_rdy", int'(div_ready), 1);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;

    // default period 5: 1,1,0,0,0
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("p5_clk", int'(clk_out), ((i % 5) < 2) ? 1 : 0);
      chk("p5_tick", int'(tick), ((i % 5) == 0) ? 1 : 0);
      chk("p5_busy", int'(busy), 1);
    end

    // update to 4 written at cnt=1
    step();
    step();
    div_in    = 8'd4;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    chk("u4_rdy", int'(div_ready), 0);
    chk("u4_cur_old", int'(cur_div), 5);
    chk("u4_c2", int'(clk_out), 0);
    step();
    step();
    chk("u4_c4_cur", int'(cur_div), 5);
    chk("u4_c4_tick", int'(tick), 0);
    step();
    chk("u4_bnd_tick", int'(tick), 1);
    chk("u4_bnd_clk", int'(clk_out), 1);
    chk("u4_bnd_cur", int'(cur_div), 4);
    chk("u4_bnd_rdy", int'(div_ready), 1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("p4_clk", int'(clk_out), ((i % 4) < 2) ? 1 : 0);
      chk("p4_tick", int'(tick), ((i % 4) == 0) ? 1 : 0);
    end

    // rejected divisors 1 and 0
    div_in    = 8'd1;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    chk("r1_err", int'(err), 1);
    chk("r1_tick", int'(tick), 1);
    chk("r1_cur", int'(cur_div), 4);
    chk("r1_rdy", int'(div_ready), 1);
    step();
    chk("r1_err_off", int'(err), 0);
    div_in    = 8'd0;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    chk("r0_err", int'(err), 1);
    chk("r0_rdy", int'(div_ready), 1);
    step();
    chk("r0_err_off", int'(err), 0);
    chk("r0_clk", int'(clk_out), 0);
    step();
    chk("r0_bnd_tick", int'(tick), 1);
    chk("r0_cur", int'(cur_div), 4);

    // move to D=6 then stop at cnt=1
    div_in    = 8'd6;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    step();
    step();
    step();
    chk("d6_tick", int'(tick), 1);
    chk("d6_cur", int'(cur_div), 6);
    step();
    en = 1'b0;
    for (int i = 2; i < 6; i++) begin
      step();
      chk("stop_clk", int'(clk_out), (i < 3) ? 1 : 0);
      chk("stop_busy", int'(busy), 1);
      chk("stop_tick", int'(tick), 0);
    end
    step();
    chk("idle_busy", int'(busy), 0);
    chk("idle_clk", int'(clk_out), 0);
    chk("idle_tick", int'(tick), 0);
    step();
    chk("idle2_tick", int'(tick), 0);
    chk("idle2_busy", int'(busy), 0);

    // start with D=2 on the same edge
    div_in    = 8'd2;
    div_valid = 1'b1;
    en        = 1'b1;
    step();
    div_valid = 1'b0;
    chk("d2_cur", int'(cur_div), 2);
    chk("d2_clk0", int'(clk_out), 1);
    chk("d2_tick0", int'(tick), 1);
    chk("d2_rdy", int'(div_ready), 1);
    for (int i = 1; i < 6; i++) begin
      step();
      chk("d2_clk", int'(clk_out), ((i % 2) == 0) ? 1 : 0);
      chk("d2_tick", int'(tick), ((i % 2) == 0) ? 1 : 0);
    end

    // accept on a boundary edge: old period rules still apply
    div_in    = 8'd7;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    chk("b7_tick", int'(tick), 1);
    chk("b7_cur_old", int'(cur_div), 2);
    chk("b7_rdy", int'(div_ready), 0);
    step();
    chk("b7_c1_clk", int'(clk_out), 0);
    chk("b7_c1_cur", int'(cur_div), 2);
    step();
    chk("b7_bnd_cur", int'(cur_div), 7);
    chk("b7_bnd_tick", int'(tick), 1);

    // reset at cnt=3 with an update pending
    div_in    = 8'd3;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    step();
    step();
    chk("pr_rdy", int'(div_ready), 0);
    chk("pr_busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    chk("ar_clk", int'(clk_out), 0);
    chk("ar_cur", int'(cur_div), 5);
    chk("ar_rdy", int'(div_ready), 1);
    chk("ar_busy", int'(busy), 0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("post_busy", int'(busy), 0);
    chk("post_cur", int'(cur_div), 5);
    chk("post_rdy", int'(div_ready), 1);
    chk("post_clk", int'(clk_out), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
